// File: rtl/ofdm_rx_pkg.sv
// ----------------------------------------------------------------------------
// ofdm_rx_pkg
// Shared definitions for the OFDM receiver front end: frame-sync state
// encodings and the default preamble/symbol timing constants (in samples).
// No ports; imported with `import ofdm_rx_pkg::*;`.
// ----------------------------------------------------------------------------
package ofdm_rx_pkg;

  localparam int STS_TIMEOUT_DEF = 320;  // STS search budget
  localparam int LTS_LEN_DEF     = 160;  // long training, GI2 included
  localparam int LTS_GI_DEF      = 32;   // LTS guard length
  localparam int SYM_LEN_DEF     = 80;   // payload symbol, CP included
  localparam int CP_LEN_DEF      = 16;   // cyclic prefix

  // Encodings are visible on the State port, so they are fixed explicitly.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_STS_SEARCH = 3'd1,
    ST_LTS        = 3'd2,
    ST_PAYLOAD    = 3'd3,
    ST_DONE       = 3'd4,
    ST_WAIT_LOW   = 3'd5
  } sync_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_sample_counter.sv
// ----------------------------------------------------------------------------
// sync_sample_counter
// Enable-gated sample counter with synchronous clear and a terminal-count
// compare. Clear wins over enable.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   en_i        : count this cycle (a valid sample)
//   clr_i       : synchronous clear to 0
//   term_i      : terminal value to compare against
//   cnt_o       : current count
//   term_o      : en_i high and count equals term_i (last sample of a phase)
// ----------------------------------------------------------------------------
module sync_sample_counter #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] term_i,
  output logic [W-1:0] cnt_o,
  output logic         term_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + W'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign term_o = en_i && (cnt_q == term_i);

endmodule

// File: rtl/sync_sequencer.sv
// ----------------------------------------------------------------------------
// sync_sequencer
// Frame timing sequencer for an OFDM receiver: STS search, LTS window,
// payload symbol pacing, frame completion. All outputs are registered and
// assert on the edge after the sample that qualifies them.
// Optional feature: define SYNC_SEQ_TIMEOUT_EN to abandon the STS search after
// STS_TIMEOUT samples (SyncTimeout pulse). Without it the search waits
// indefinitely and SyncTimeout is tied low.
// Ports:
//   Clk, Rst_n   : clock (rising edge), asynchronous active-low reset
//   DataEnable   : sample valid / frame active; low aborts an active frame
//   PeakFinded   : STS end flag from the peak detector
//   SymbolNum    : payload symbol count, latched at the end of the LTS
//   FrameStart   : pulse, STS end accepted
//   LtsWindow    : high for LTS samples LTS_GI..LTS_LEN-1
//   SymbolStart  : pulse at the first post-CP sample of each payload symbol
//   SymbolIndex  : 0-based index of the current payload symbol
//   FrameDone    : pulse, all payload symbols consumed
//   SyncTimeout  : pulse, STS search expired
//   State        : current state encoding (ofdm_rx_pkg::sync_state_e)
// ----------------------------------------------------------------------------
module sync_sequencer
  import ofdm_rx_pkg::*;
#(
  parameter int STS_TIMEOUT = STS_TIMEOUT_DEF,
  parameter int LTS_LEN     = LTS_LEN_DEF,
  parameter int LTS_GI      = LTS_GI_DEF,
  parameter int SYM_LEN     = SYM_LEN_DEF,
  parameter int CP_LEN      = CP_LEN_DEF
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       DataEnable,
  input  logic       PeakFinded,
  input  logic [7:0] SymbolNum,
  output logic       FrameStart,
  output logic       LtsWindow,
  output logic       SymbolStart,
  output logic [7:0] SymbolIndex,
  output logic       FrameDone,
  output logic       SyncTimeout,
  output logic [2:0] State
);

  localparam int CNT_W = $clog2(max3(STS_TIMEOUT, LTS_LEN, SYM_LEN));

  localparam logic [CNT_W-1:0] LTS_END = CNT_W'(LTS_LEN - 1);
  localparam logic [CNT_W-1:0] LTS_GI_C = CNT_W'(LTS_GI);
  localparam logic [CNT_W-1:0] SYM_END = CNT_W'(SYM_LEN - 1);
  localparam logic [CNT_W-1:0] CP_C    = CNT_W'(CP_LEN);
`ifdef SYNC_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] STS_END = CNT_W'(STS_TIMEOUT - 1);
`endif

  sync_state_e      state_q, state_d;
  logic [7:0]       sym_idx_q, sym_idx_d;
  logic [7:0]       sym_num_q, sym_num_d;
  logic             frame_start_q, frame_start_d;
  logic             lts_win_q, lts_win_d;
  logic             sym_start_q, sym_start_d;
  logic             frame_done_q, frame_done_d;
  logic             sync_to_q, sync_to_d;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_term;
  logic             term_hit;
  logic             payload_wrap;
  logic             cnt_clr;

  // Terminal value depends only on the current state, keeping the compare
  // out of the next-state loop.
  always_comb begin
    cnt_term = LTS_END;
    case (state_q)
      ST_PAYLOAD:    cnt_term = SYM_END;
`ifdef SYNC_SEQ_TIMEOUT_EN
      ST_STS_SEARCH: cnt_term = STS_END;
`endif
      default:       cnt_term = LTS_END;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    sym_idx_d     = sym_idx_q;
    sym_num_d     = sym_num_q;
    frame_start_d = 1'b0;
    lts_win_d     = 1'b0;
    sym_start_d   = 1'b0;
    sync_to_d     = 1'b0;
    payload_wrap  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (DataEnable) state_d = ST_STS_SEARCH;
      end
      ST_STS_SEARCH: begin
        if (!DataEnable) begin
          state_d = ST_IDLE;
        end else if (PeakFinded) begin
          // Peak beats an expiry on the same sample.
          state_d       = ST_LTS;
          frame_start_d = 1'b1;
        end
`ifdef SYNC_SEQ_TIMEOUT_EN
        else if (term_hit) begin
          state_d   = ST_WAIT_LOW;
          sync_to_d = 1'b1;
        end
`endif
      end
      ST_LTS: begin
        if (!DataEnable) begin
          state_d = ST_IDLE;
        end else begin
          // The counter never passes LTS_END here, so only the lower bound
          // of the window needs checking.
          lts_win_d = (cnt >= LTS_GI_C);
          if (term_hit) begin
            sym_num_d = SymbolNum;
            sym_idx_d = 8'd0;
            state_d   = (SymbolNum == 8'd0) ? ST_DONE : ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (!DataEnable) begin
          state_d   = ST_IDLE;
          sym_idx_d = 8'd0;
        end else begin
          sym_start_d = (cnt == CP_C);
          if (term_hit) begin
            payload_wrap = 1'b1;
            if (sym_idx_q == sym_num_q - 8'd1) begin
              state_d   = ST_DONE;
              sym_idx_d = 8'd0;
            end else begin
              sym_idx_d = sym_idx_q + 8'd1;
            end
          end
        end
      end
      ST_DONE:     state_d = ST_WAIT_LOW;
      ST_WAIT_LOW: if (!DataEnable) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    // DONE lasts exactly one cycle, so the pulse is simply "entering DONE".
    frame_done_d = (state_d == ST_DONE);
  end

  // Every phase starts counting from zero; payload also restarts per symbol.
  assign cnt_clr = (state_d != state_q) || payload_wrap;

  sync_sample_counter #(.W(CNT_W)) u_cnt (
    .clk    (Clk),
    .rst_n  (Rst_n),
    .en_i   (DataEnable),
    .clr_i  (cnt_clr),
    .term_i (cnt_term),
    .cnt_o  (cnt),
    .term_o (term_hit)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q       <= ST_IDLE;
      sym_idx_q     <= 8'd0;
      sym_num_q     <= 8'd0;
      frame_start_q <= 1'b0;
      lts_win_q     <= 1'b0;
      sym_start_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      sync_to_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      sym_idx_q     <= sym_idx_d;
      sym_num_q     <= sym_num_d;
      frame_start_q <= frame_start_d;
      lts_win_q     <= lts_win_d;
      sym_start_q   <= sym_start_d;
      frame_done_q  <= frame_done_d;
      sync_to_q     <= sync_to_d;
    end
  end

  assign FrameStart  = frame_start_q;
  assign LtsWindow   = lts_win_q;
  assign SymbolStart = sym_start_q;
  assign SymbolIndex = sym_idx_q;
  assign FrameDone   = frame_done_q;
  assign SyncTimeout = sync_to_q;
  assign State       = state_q;

endmodule

// File: tb/tb_sync_sequencer.sv
// ----------------------------------------------------------------------------
// tb_sync_sequencer
// Self-checking bench for sync_sequencer. A frame-level reference model
// (phase + sample position, payload timing by division/modulo) predicts every
// registered output each cycle; directed frames pin the model with literal
// timings, then randomized bursts exercise the rest.
// Honors SYNC_SEQ_TIMEOUT_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_sync_sequencer;
  import ofdm_rx_pkg::*;

  localparam int STS_TIMEOUT = 320;
  localparam int LTS_LEN     = 160;
  localparam int LTS_GI      = 32;
  localparam int SYM_LEN     = 80;
  localparam int CP_LEN      = 16;
`ifdef SYNC_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       DataEnable = 1'b0;
  logic       PeakFinded = 1'b0;
  logic [7:0] SymbolNum = 8'd0;
  logic       FrameStart, LtsWindow, SymbolStart, FrameDone, SyncTimeout;
  logic [7:0] SymbolIndex;
  logic [2:0] State;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  sync_sequencer #(
    .STS_TIMEOUT(STS_TIMEOUT), .LTS_LEN(LTS_LEN), .LTS_GI(LTS_GI),
    .SYM_LEN(SYM_LEN), .CP_LEN(CP_LEN)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n), .DataEnable(DataEnable), .PeakFinded(PeakFinded),
    .SymbolNum(SymbolNum), .FrameStart(FrameStart), .LtsWindow(LtsWindow),
    .SymbolStart(SymbolStart), .SymbolIndex(SymbolIndex), .FrameDone(FrameDone),
    .SyncTimeout(SyncTimeout), .State(State)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // pos = samples already consumed in the current phase; payload pos runs
  // over the whole payload, symbol and in-symbol offset derived from it.
  typedef struct {
    sync_state_e st;
    int          pos;
    int          num;
    logic        fs, lw, ss, fd, to;
    logic [7:0]  si;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.st = ST_IDLE; r.pos = 0; r.num = 0;
    r.fs = 0; r.lw = 0; r.ss = 0; r.fd = 0; r.to = 0; r.si = 8'd0;
    return r;
  endfunction

  function automatic model_t model_step(model_t c, logic de, logic pk, logic [7:0] sn);
    model_t n = c;
    n.fs = 0; n.lw = 0; n.ss = 0; n.fd = 0; n.to = 0; n.si = 8'd0;
    case (c.st)
      ST_IDLE: if (de) begin n.st = ST_STS_SEARCH; n.pos = 0; end
      ST_STS_SEARCH:
        if (!de) begin n.st = ST_IDLE; n.pos = 0; end
        else if (pk) begin n.st = ST_LTS; n.pos = 0; n.fs = 1; end
        else if (TO_EN && c.pos + 1 == STS_TIMEOUT) begin n.st = ST_WAIT_LOW; n.to = 1; end
        else n.pos = c.pos + 1;
      ST_LTS:
        if (!de) begin n.st = ST_IDLE; n.pos = 0; end
        else begin
          n.lw = (c.pos >= LTS_GI) && (c.pos < LTS_LEN);
          if (c.pos == LTS_LEN - 1) begin
            n.num = int'(sn); n.pos = 0;
            if (sn == 8'd0) begin n.st = ST_DONE; n.fd = 1; end
            else n.st = ST_PAYLOAD;
          end else n.pos = c.pos + 1;
        end
      ST_PAYLOAD:
        if (!de) begin n.st = ST_IDLE; n.pos = 0; end
        else begin
          n.ss = ((c.pos % SYM_LEN) == CP_LEN);
          if (c.pos == c.num * SYM_LEN - 1) begin n.st = ST_DONE; n.fd = 1; n.pos = 0; end
          else begin n.pos = c.pos + 1; n.si = 8'(n.pos / SYM_LEN); end
        end
      ST_DONE:     n.st = ST_WAIT_LOW;
      ST_WAIT_LOW: if (!de) n.st = ST_IDLE;
      default:     n.st = ST_IDLE;
    endcase
    return n;
  endfunction

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) m <= model_reset();
    else        m <= model_step(m, DataEnable, PeakFinded, SymbolNum);
  end

  // Single compare process, away from the active edge.
  always @(negedge Clk) begin
    if (chk_en) begin
      check("State",       32'(State),       32'(m.st));
      check("FrameStart",  32'(FrameStart),  32'(m.fs));
      check("LtsWindow",   32'(LtsWindow),   32'(m.lw));
      check("SymbolStart", 32'(SymbolStart), 32'(m.ss));
      check("SymbolIndex", 32'(SymbolIndex), 32'(m.si));
      check("FrameDone",   32'(FrameDone),   32'(m.fd));
      check("SyncTimeout", 32'(SyncTimeout), 32'(m.to));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input logic de, input logic pk, input logic [7:0] sn);
    DataEnable = de; PeakFinded = pk; SymbolNum = sn;
    @(posedge Clk);
    @(negedge Clk);
    #1;
  endtask

  // From IDLE: one IDLE sample, then STS samples 1..peak_at with the peak on the last.
  task automatic sts_to_peak(input int peak_at, input logic [7:0] sn);
    cyc(1'b1, 1'b0, sn);
    for (int s = 1; s < peak_at; s++) cyc(1'b1, 1'b0, sn);
    cyc(1'b1, 1'b1, sn);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, 32'(State), 0);
    check({tag, "_fs"},    32'(FrameStart), 0);
    check({tag, "_lw"},    32'(LtsWindow), 0);
    check({tag, "_ss"},    32'(SymbolStart), 0);
    check({tag, "_si"},    32'(SymbolIndex), 0);
    check({tag, "_fd"},    32'(FrameDone), 0);
    check({tag, "_to"},    32'(SyncTimeout), 0);
  endtask

  int lw_cnt, ss_cnt, fd_cnt;
  int ss_p[$];
  int ss_i[$];
  int exp_p[3] = '{16, 96, 176};

  initial begin
    repeat (3) @(negedge Clk);
    #1;
    chk_en = 1'b1;
    check_all_zero("reset");
    Rst_n = 1'b1;
    cyc(1'b0, 1'b0, 8'd0);
    check("idle_after_reset", 32'(State), 0);

    // ---- full frame, 3 symbols, peak at STS sample 100 ----
    cyc(1'b1, 1'b0, 8'd3);
    check("sts_entry", 32'(State), 1);
    for (int s = 1; s < 100; s++) cyc(1'b1, 1'b0, 8'd3);
    check("fs_before_peak", 32'(FrameStart), 0);
    cyc(1'b1, 1'b1, 8'd3);
    check("fs_after_peak", 32'(FrameStart), 1);
    check("state_lts", 32'(State), 2);
    lw_cnt = 0;
    for (int j = 0; j < LTS_LEN; j++) begin
      cyc(1'b1, 1'b0, (j == LTS_LEN - 1) ? 8'd3 : 8'($urandom_range(0, 255)));
      lw_cnt += int'(LtsWindow);
    end
    check("lw_high_cycles", 32'(lw_cnt), 128);
    check("state_payload", 32'(State), 3);
    fd_cnt = 0;
    for (int p = 0; p < 240; p++) begin
      cyc(1'b1, 1'b0, 8'($urandom_range(0, 255)));
      if (SymbolStart) begin ss_p.push_back(p); ss_i.push_back(int'(SymbolIndex)); end
      if (p < 239) fd_cnt += int'(FrameDone);
    end
    check("fd_early", 32'(fd_cnt), 0);
    check("fd_after_240", 32'(FrameDone), 1);
    check("state_done", 32'(State), 4);
    check("ss_count", 32'(ss_p.size()), 3);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("ss_pos%0d", k), (k < ss_p.size()) ? 32'(ss_p[k]) : 32'hFFFF_FFFF, 32'(exp_p[k]));
      check($sformatf("ss_idx%0d", k), (k < ss_i.size()) ? 32'(ss_i[k]) : 32'hFFFF_FFFF, 32'(k));
    end
    cyc(1'b1, 1'b0, 8'd3);
    check("wait_low", 32'(State), 5);
    check("fd_one_cycle", 32'(FrameDone), 0);
    repeat (5) cyc(1'b1, 1'b1, 8'd3);
    check("no_resync", 32'(State), 5);
    check("no_resync_fs", 32'(FrameStart), 0);
    cyc(1'b0, 1'b0, 8'd0);
    check("idle_after_wait", 32'(State), 0);

    // ---- STS search with no peak for 320 samples ----
    cyc(1'b1, 1'b0, 8'd0);
    for (int s = 1; s <= STS_TIMEOUT; s++) cyc(1'b1, 1'b0, 8'd0);
    check("timeout_pulse", 32'(SyncTimeout), 32'(TO_EN));
    check("timeout_state", 32'(State), TO_EN ? 32'd5 : 32'd1);
    repeat (10) cyc(1'b1, 1'b0, 8'd0);
    check("timeout_one_cycle", 32'(SyncTimeout), 0);
    check("timeout_hold", 32'(State), TO_EN ? 32'd5 : 32'd1);
    cyc(1'b0, 1'b0, 8'd0);
    check("timeout_idle", 32'(State), 0);

    // ---- peak on the 320th sample wins over expiry ----
    sts_to_peak(STS_TIMEOUT, 8'd1);
    check("late_peak_fs", 32'(FrameStart), 1);
    check("late_peak_no_to", 32'(SyncTimeout), 0);
    check("late_peak_state", 32'(State), 2);
    cyc(1'b0, 1'b0, 8'd0);
    check_all_zero("late_peak_abort");

    // ---- SymbolNum = 0 at the latch point ----
    sts_to_peak(5, 8'd7);
    ss_cnt = 0;
    for (int j = 0; j < LTS_LEN; j++) begin
      cyc(1'b1, 1'b0, (j == LTS_LEN - 1) ? 8'd0 : 8'($urandom_range(1, 255)));
      ss_cnt += int'(SymbolStart);
    end
    check("zero_sym_fd", 32'(FrameDone), 1);
    check("zero_sym_done", 32'(State), 4);
    cyc(1'b1, 1'b0, 8'd5);
    ss_cnt += int'(SymbolStart);
    check("zero_sym_wait", 32'(State), 5);
    check("zero_sym_no_ss", 32'(ss_cnt), 0);
    cyc(1'b0, 1'b0, 8'd0);

    // ---- DataEnable drop in payload symbol 1 ----
    sts_to_peak(10, 8'd4);
    for (int j = 0; j < LTS_LEN; j++) cyc(1'b1, 1'b0, 8'd4);
    for (int p = 0; p < 100; p++) cyc(1'b1, 1'b0, 8'd4);
    check("drop_pre_idx", 32'(SymbolIndex), 1);
    cyc(1'b0, 1'b0, 8'd4);
    check_all_zero("drop");
    fd_cnt = 0;
    repeat (4) begin cyc(1'b0, 1'b0, 8'd4); fd_cnt += int'(FrameDone); end
    check("drop_no_fd", 32'(fd_cnt), 0);

    // ---- reset mid-LTS ----
    sts_to_peak(3, 8'd2);
    for (int j = 0; j < 50; j++) cyc(1'b1, 1'b0, 8'd2);
    check("pre_reset_lw", 32'(LtsWindow), 1);
    #1 Rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge Clk);
    @(negedge Clk);
    #1 Rst_n = 1'b1;
    #1;
    check("release_idle", 32'(State), 0);
    cyc(1'b1, 1'b0, 8'd2);
    check("release_sts", 32'(State), 1);
    check("release_no_pulse", 32'(FrameStart), 0);
    cyc(1'b0, 1'b0, 8'd0);

    // ---- randomized bursts ----
    for (int b = 0; b < 60; b++) begin
      int len, pk_pct, gap;
      len    = $urandom_range(20, 700);
      pk_pct = $urandom_range(0, 3);
      gap    = $urandom_range(1, 4);
      for (int i = 0; i < len; i++)
        cyc(1'b1, 1'($urandom_range(0, 99) < pk_pct), 8'($urandom_range(0, 3)));
      for (int i = 0; i < gap; i++)
        cyc(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sync_sequencer.md
SYNC_SEQUENCER -- requirements
Module: sync_sequencer

Interface
REQ-001 SHALL have parameter STS_TIMEOUT, 320, max DataEnable samples in STS_SEARCH before timeout.
REQ-002 SHALL have parameter LTS_LEN, 160, long-training length in samples, GI2 included.
REQ-003 SHALL have parameter LTS_GI, 32, LTS guard length in samples.
REQ-004 SHALL have parameter SYM_LEN, 80, payload symbol length in samples, CP included.
REQ-005 SHALL have parameter CP_LEN, 16, cyclic-prefix length in samples.
REQ-006 SHALL have port Clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port Rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have port DataEnable  input  1  sample valid / frame active.
REQ-009 SHALL have port PeakFinded  input  1  STS end flag from the peak detector (level).
REQ-010 SHALL have port SymbolNum  input  8  payload symbol count.
REQ-011 SHALL have port FrameStart  output  1  one-cycle pulse, STS end accepted.
REQ-012 SHALL have port LtsWindow  output  1  high on LTS samples LTS_GI..LTS_LEN-1.
REQ-013 SHALL have port SymbolStart  output  1  one-cycle pulse at the first post-CP sample of each payload symbol.
REQ-014 SHALL have port SymbolIndex  output  8  index of the current payload symbol, 0-based.
REQ-015 SHALL have port FrameDone  output  1  one-cycle pulse, all payload symbols consumed.
REQ-016 SHALL have port SyncTimeout  output  1  one-cycle pulse, STS search expired.
REQ-017 SHALL have port State  output  3  current state encoding.

Function
REQ-018 SHALL implement the states IDLE, STS_SEARCH, LTS, PAYLOAD, DONE and WAIT_LOW.
REQ-019 SHALL register all outputs, each asserting on the edge after the qualifying input sample.
REQ-020 SHALL advance the sample counter only on cycles with DataEnable=1.
REQ-021 IDLE: SHALL go to STS_SEARCH with the counter cleared when DataEnable=1.
REQ-022 STS_SEARCH: SHALL go to LTS on PeakFinded=1, pulsing FrameStart and clearing the counter.
REQ-023 STS_SEARCH: when the counter reaches STS_TIMEOUT with no peak, SHALL pulse SyncTimeout and go to WAIT_LOW.
REQ-024 SHALL give PeakFinded priority when it arrives on the same cycle as timeout expiry.
REQ-025 LTS: SHALL drive LtsWindow=1 for sample counts LTS_GI..LTS_LEN-1 and 0 otherwise.
REQ-026 LTS: after LTS_LEN samples, SHALL latch SymbolNum and go to PAYLOAD, or to DONE if the latched value is 0.
REQ-027 PAYLOAD: SHALL pulse SymbolStart at in-symbol count CP_LEN, with SymbolIndex valid in that cycle.
REQ-028 PAYLOAD: SHALL increment SymbolIndex at each symbol boundary and wrap the in-symbol count at SYM_LEN-1.
REQ-029 PAYLOAD: after latched SymbolNum x SYM_LEN samples, SHALL go to DONE.
REQ-030 DONE: SHALL pulse FrameDone for one cycle and then go to WAIT_LOW.
REQ-031 WAIT_LOW: SHALL hold until DataEnable=0 and then go to IDLE, so no re-sync happens within the same burst.
REQ-032 SHALL abort to IDLE on DataEnable=0 in STS_SEARCH, LTS or PAYLOAD, clearing counters, LtsWindow and SymbolIndex, with no FrameDone.
REQ-033 SHALL ignore SymbolNum changes after the latch point.

Reset
REQ-034 SHALL, on Rst_n=0, asynchronously set State=IDLE, all counters to 0 and all outputs to 0.
REQ-035 SHALL leave no pulse pending on reset release mid-frame; the first cycle after release is in IDLE.

Configuration
REQ-036 With macro SYNC_SEQ_TIMEOUT_EN defined, SHALL implement the STS_TIMEOUT check as specified.
REQ-037 Without SYNC_SEQ_TIMEOUT_EN, SHALL stay in STS_SEARCH indefinitely, with SyncTimeout tied to 0 and the timeout compare removed.

Structure
REQ-038 SHALL put the state encodings and the default LTS_LEN, LTS_GI, SYM_LEN and CP_LEN constants in the shared package ofdm_rx_pkg.
REQ-039 SHALL use one sub-module, sync_sample_counter: an enable-gated counter with synchronous clear and a terminal-count compare.

Verification
REQ-040 SHALL cover: DataEnable high, PeakFinded at sample 100, SymbolNum=3 -> FrameStart 1 cycle after the peak; LtsWindow high for 128 samples; SymbolStart at payload samples 16, 96, 176 with SymbolIndex 0, 1, 2; FrameDone after 240 payload samples.
REQ-041 SHALL cover: no PeakFinded for 320 samples -> SyncTimeout pulse, state WAIT_LOW until DataEnable=0, then IDLE.
REQ-042 SHALL cover: PeakFinded on the 320th sample -> FrameStart, no SyncTimeout.
REQ-043 SHALL cover: SymbolNum=0 -> DONE straight after LTS, FrameDone, no SymbolStart.
REQ-044 SHALL cover: DataEnable dropped mid-PAYLOAD (symbol 1) -> IDLE next cycle, all outputs 0, no FrameDone.
REQ-045 SHALL cover: Rst_n asserted mid-LTS -> outputs 0 immediately, IDLE after release.
